// File: rtl/dmem_access_ctrl_if.sv
// Bundle of the CPU request/response handshake and the data-memory port
// around dmem_access_ctrl. The "master" side is the environment (CPU stage
// plus the data memory it owns); the "slave" side is the controller itself.
interface dmem_access_ctrl_if #(
  parameter int ADDR_W = 11
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic [1:0]        resp_exc;
  logic [31:0]       resp_badvaddr;

  logic              dm_ena;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic [2:0]        dm_data_w;
  logic              dm_data_sign;
  logic [31:0]       dm_rdata;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, resp_ready, dm_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_exc, resp_badvaddr,
    input  dm_ena, dm_we, dm_addr, dm_wdata, dm_data_w, dm_data_sign
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, resp_ready, dm_rdata,
    output req_ready, resp_valid, resp_rdata, resp_exc, resp_badvaddr,
    output dm_ena, dm_we, dm_addr, dm_wdata, dm_data_w, dm_data_sign
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Load/store initiator for the byte-addressable data memory. Takes one CPU
// request at a time, checks alignment and range of the virtual address,
// runs a single-cycle memory access when the request is legal and returns
// either the extended load data or an exception code.
module dmem_access_ctrl #(
  parameter logic [31:0] DATA_BASE = 32'h1001_0000,
  parameter int          MEM_BYTES = 1024,
  parameter int          ADDR_W    = 11
) (
  input logic               clk,
  input logic               rst,
  dmem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  state_e            state_q, state_d;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] offset_q;
  logic [31:0]       wdata_q;
  logic [2:0]        width_q;
  logic              sign_q;
  logic [31:0]       rdata_q;
  logic [1:0]        exc_q;
  logic [31:0]       badVaddr_q;

  logic [2:0]        reqSize;
  logic              reqStore;
  logic              misaligned;
  logic [31:0]       accessOffset;
  logic              outOfRange;
  logic [1:0]        reqExc;
  logic              opStore_q;
  logic [31:0]       loadExt;
  logic              reqReady, respValid, dmEna, dmWe;

  // Decode the incoming request: size, direction and the fault it would raise
  always_comb begin
    reqSize = 3'd4;
    case (bus.req_op)
      3'd0, 3'd1, 3'd5: reqSize = 3'd1;
      3'd2, 3'd3, 3'd6: reqSize = 3'd2;
      default:          reqSize = 3'd4;
    endcase
    reqStore     = bus.req_op[2] & (bus.req_op[1] | bus.req_op[0]);
    misaligned   = ((reqSize == 3'd2) && bus.req_addr[0]) ||
                   ((reqSize == 3'd4) && (bus.req_addr[1:0] != 2'b00));
    accessOffset = bus.req_addr - DATA_BASE;
    // 33-bit sum so an offset that wrapped near 2^32 cannot overflow back into range
    outOfRange   = ({1'b0, accessOffset} + {30'b0, reqSize}) > MEM_LIMIT;
    reqExc       = 2'd0;
    if (misaligned)      reqExc = reqStore ? 2'd2 : 2'd1;
    else if (outOfRange) reqExc = 2'd3;
  end

  // Extend the raw memory word according to the latched load opcode
  always_comb begin
    opStore_q = op_q[2] & (op_q[1] | op_q[0]);
    loadExt   = bus.dm_rdata;
    case (op_q)
      3'd0:    loadExt = {{24{bus.dm_rdata[7]}}, bus.dm_rdata[7:0]};
      3'd1:    loadExt = {24'b0, bus.dm_rdata[7:0]};
      3'd2:    loadExt = {{16{bus.dm_rdata[15]}}, bus.dm_rdata[15:0]};
      3'd3:    loadExt = {16'b0, bus.dm_rdata[15:0]};
      default: loadExt = bus.dm_rdata;
    endcase
  end

  // State register; reset drops out of ACCESS at once so a store cannot commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state plus the handshake and memory strobes decoded from the state
  always_comb begin
    state_d   = state_q;
    reqReady  = 1'b0;
    respValid = 1'b0;
    dmEna     = 1'b0;
    dmWe      = 1'b0;
    case (state_q)
      IDLE: begin
        reqReady = 1'b1;
        if (bus.req_valid) state_d = (reqExc != 2'd0) ? RESP : ACCESS;
      end
      ACCESS: begin
        dmEna   = 1'b1;
        dmWe    = opStore_q;
        state_d = RESP;
      end
      RESP: begin
        respValid = 1'b1;
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the request on acceptance and capture load data at the end of ACCESS
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= 3'd0;
      offset_q   <= '0;
      wdata_q    <= 32'd0;
      width_q    <= 3'd0;
      sign_q     <= 1'b0;
      rdata_q    <= 32'd0;
      exc_q      <= 2'd0;
      badVaddr_q <= 32'd0;
    end else if ((state_q == IDLE) && bus.req_valid) begin
      op_q       <= bus.req_op;
      offset_q   <= accessOffset[ADDR_W-1:0];
      wdata_q    <= bus.req_wdata;
      width_q    <= reqSize;
      sign_q     <= (bus.req_op == 3'd0) || (bus.req_op == 3'd2);
      rdata_q    <= 32'd0;
      exc_q      <= reqExc;
      badVaddr_q <= (reqExc != 2'd0) ? bus.req_addr : 32'd0;
    end else if ((state_q == ACCESS) && !opStore_q) begin
      rdata_q    <= loadExt;
    end
  end

  assign bus.req_ready     = reqReady;
  assign bus.resp_valid    = respValid;
  assign bus.resp_rdata    = rdata_q;
  assign bus.resp_exc      = exc_q;
  assign bus.resp_badvaddr = badVaddr_q;
  assign bus.dm_ena        = dmEna;
  assign bus.dm_we         = dmWe;
  assign bus.dm_addr       = offset_q;
  assign bus.dm_wdata      = wdata_q;
  assign bus.dm_data_w     = width_q;
  assign bus.dm_data_sign  = sign_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Testbench for dmem_access_ctrl: a byte-array data memory answers the DM
// port, a driver issues directed and random load/store requests, and a
// monitor compares every memory access and response against a reference
// model's expectations kept in a scoreboard queue.
module tb_dmem_access_ctrl;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          MEMSZ = 1024;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  exc;
    logic [31:0] badVaddr;
    bit          expAccess;
    bit          sawAccess;
    bit          sawValid;
    bit          isStore;
    logic [10:0] dmAddr;
    logic [2:0]  width;
    bit          sign;
    logic [31:0] wdata;
    int          accCycle;
  } expect_t;

  logic clk = 1'b0;
  logic rst;
  int   cycle = 0;
  int   nChecks = 0;
  int   nPass = 0;

  expect_t    sbQ[$];
  logic [7:0] devMem [MEMSZ] = '{default: 8'h00};
  logic [7:0] refMem [MEMSZ] = '{default: 8'h00};

  logic [9:0]  a0, a1, a2, a3;
  logic [31:0] rawWord, memRead;

  dmem_access_ctrl_if #(.ADDR_W(11)) bus();

  dmem_access_ctrl #(.DATA_BASE(BASE), .MEM_BYTES(MEMSZ), .ADDR_W(11)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // Data memory device: combinational little-endian read, write on the clock edge
  assign a0 = bus.dm_addr[9:0];
  assign a1 = a0 + 10'd1;
  assign a2 = a0 + 10'd2;
  assign a3 = a0 + 10'd3;
  assign rawWord = {devMem[a3], devMem[a2], devMem[a1], devMem[a0]};

  always_comb begin
    memRead = rawWord;
    case (bus.dm_data_w)
      3'd1:    memRead = bus.dm_data_sign ? {{24{rawWord[7]}}, rawWord[7:0]} : {24'b0, rawWord[7:0]};
      3'd2:    memRead = bus.dm_data_sign ? {{16{rawWord[15]}}, rawWord[15:0]} : {16'b0, rawWord[15:0]};
      default: memRead = rawWord;
    endcase
  end

  assign bus.dm_rdata = (bus.dm_ena && !bus.dm_we) ? memRead : 32'hA5A5_A5A5;

  always @(posedge clk) begin
    if (bus.dm_ena && bus.dm_we) begin
      for (int i = 0; i < 4; i++)
        if (i < int'(bus.dm_data_w)) devMem[a0 + 10'(i)] <= bus.dm_wdata[8*i +: 8];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic failNow(input string name);
    nChecks++;
    $display("[TB] FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference model: architectural result of one request, updating the model memory for legal stores
  function automatic expect_t model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    expect_t     e;
    int          size;
    bit          store;
    logic [31:0] off;
    longint      value;
    e = '{default: 0};
    size = (op == 0 || op == 1 || op == 5) ? 1 : (op == 2 || op == 3 || op == 6) ? 2 : 4;
    store = (op >= 5);
    e.isStore = store;
    e.width = 3'(size);
    e.sign = (op == 0 || op == 2);
    e.wdata = wdata;
    off = addr - BASE;
    if ((size == 2 && addr % 2 != 0) || (size == 4 && addr % 4 != 0)) e.exc = store ? 2'd2 : 2'd1;
    else if (longint'(off) + size > MEMSZ) e.exc = 2'd3;
    if (e.exc != 0) begin
      e.badVaddr = addr;
    end else begin
      e.expAccess = 1;
      e.dmAddr = off[10:0];
      if (store) begin
        for (int i = 0; i < size; i++) refMem[off + i] = wdata[8*i +: 8];
      end else begin
        value = 0;
        for (int i = 0; i < size; i++) value += longint'(refMem[off + i]) << (8 * i);
        if (e.sign && value >= (longint'(1) << (8 * size - 1))) value -= longint'(1) << (8 * size);
        e.rdata = value[31:0];
      end
    end
    return e;
  endfunction

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
    checkOutput({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd0);
    checkOutput({tag, " resp_rdata"}, bus.resp_rdata, 32'd0);
    checkOutput({tag, " resp_exc"}, 32'(bus.resp_exc), 32'd0);
    checkOutput({tag, " resp_badvaddr"}, bus.resp_badvaddr, 32'd0);
    checkOutput({tag, " dm_ena"}, 32'(bus.dm_ena), 32'd0);
    checkOutput({tag, " dm_we"}, 32'(bus.dm_we), 32'd0);
    checkOutput({tag, " dm_addr"}, 32'(bus.dm_addr), 32'd0);
    checkOutput({tag, " dm_wdata"}, bus.dm_wdata, 32'd0);
    checkOutput({tag, " dm_data_w"}, 32'(bus.dm_data_w), 32'd0);
    checkOutput({tag, " dm_data_sign"}, 32'(bus.dm_data_sign), 32'd0);
  endtask

  // Issue one request, optionally stall the response, and wait for its handshake
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata, input int stall);
    int guard;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    if (!bus.req_ready) begin failNow("req_ready timeout"); return; end
    sbQ.push_back(model(op, addr, wdata));
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_addr = addr;
    bus.req_wdata = wdata;
    bus.resp_ready = (stall == 0);
    @(posedge clk); #1;
    sbQ[sbQ.size()-1].accCycle = cycle;
    bus.req_valid = 1'b0;
    bus.req_op = 3'($urandom);
    bus.req_addr = $urandom;
    bus.req_wdata = $urandom;
    guard = 0;
    while (!bus.resp_valid && guard < 10) begin @(posedge clk); #1; guard++; end
    if (!bus.resp_valid) begin failNow("resp_valid timeout"); sbQ.delete(); return; end
    if (stall > 0) begin
      bus.req_valid = 1'b1;
      bus.req_op = 3'd4;
      bus.req_addr = BASE;
      repeat (stall) begin @(posedge clk); #1; end
      bus.req_valid = 1'b0;
      bus.resp_ready = 1'b1;
    end
    guard = 0;
    while (bus.resp_valid && guard < 10) begin @(posedge clk); #1; guard++; end
    if (bus.resp_valid) failNow("response handshake timeout");
    bus.resp_ready = 1'b0;
  endtask

  // Monitor: checks each memory access and each presented response against the scoreboard head
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.dm_ena) begin
        if (sbQ.size() == 0 || !sbQ[0].expAccess || sbQ[0].sawAccess) begin
          failNow("unexpected dm_ena pulse");
        end else begin
          checkOutput("access cycle", 32'(cycle - sbQ[0].accCycle + 1), 32'd1);
          checkOutput("dm_we", 32'(bus.dm_we), 32'(sbQ[0].isStore));
          checkOutput("dm_addr", 32'(bus.dm_addr), 32'(sbQ[0].dmAddr));
          checkOutput("dm_data_w", 32'(bus.dm_data_w), 32'(sbQ[0].width));
          checkOutput("dm_data_sign", 32'(bus.dm_data_sign), 32'(sbQ[0].sign));
          if (sbQ[0].isStore) checkOutput("dm_wdata", bus.dm_wdata, sbQ[0].wdata);
          sbQ[0].sawAccess = 1;
        end
      end
      if (bus.resp_valid) begin
        if (sbQ.size() == 0) begin
          failNow("unexpected resp_valid");
        end else begin
          if (!sbQ[0].sawValid) begin
            checkOutput("resp latency", 32'(cycle - sbQ[0].accCycle + 1), (sbQ[0].exc != 0) ? 32'd1 : 32'd2);
            sbQ[0].sawValid = 1;
          end
          checkOutput("resp_rdata", bus.resp_rdata, sbQ[0].rdata);
          checkOutput("resp_exc", 32'(bus.resp_exc), 32'(sbQ[0].exc));
          checkOutput("resp_badvaddr", bus.resp_badvaddr, sbQ[0].badVaddr);
          checkOutput("req_ready while resp pending", 32'(bus.req_ready), 32'd0);
          if (bus.resp_ready) begin
            checkOutput("dm access issued", 32'(sbQ[0].sawAccess), 32'(sbQ[0].expAccess));
            void'(sbQ.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] addr;
    int          guard;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op = 3'd0;
    bus.req_addr = 32'd0;
    bus.req_wdata = 32'd0;
    bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkResetOutputs("reset");

    // Directed cases
    applyStimulus(3'd7, 32'h1001_0004, 32'hDEAD_BEEF, 0);
    applyStimulus(3'd4, 32'h1001_0004, 32'h0, 0);
    applyStimulus(3'd5, 32'h1001_0010, 32'h0000_0080, 0);
    applyStimulus(3'd0, 32'h1001_0010, 32'h0, 0);
    applyStimulus(3'd1, 32'h1001_0010, 32'h0, 0);
    applyStimulus(3'd2, 32'h1001_0003, 32'h0, 0);
    applyStimulus(3'd7, 32'h1001_0002, 32'h1111_2222, 0);
    applyStimulus(3'd4, 32'h1001_03FC, 32'h0, 0);
    applyStimulus(3'd4, 32'h1001_0400, 32'h0, 0);
    applyStimulus(3'd0, 32'h1000_FFFF, 32'h0, 0);
    applyStimulus(3'd4, 32'h1001_0004, 32'h0, 5);

    // Reset during the ACCESS cycle of a store: the store must not land
    applyStimulus(3'd7, 32'h1001_0020, 32'hCAFE_F00D, 0);
    guard = 0;
    while (!bus.req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    bus.req_valid = 1'b1;
    bus.req_op = 3'd7;
    bus.req_addr = 32'h1001_0020;
    bus.req_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checkOutput("dm_ena in ACCESS before reset", 32'(bus.dm_ena), 32'd1);
    rst = 1'b1;
    #1;
    checkResetOutputs("mid-access reset");
    sbQ.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(3'd4, 32'h1001_0020, 32'h0, 0);

    // Random traffic, biased toward a small window and the top boundary
    for (int n = 0; n < 150; n++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       addr = $urandom;
        1:       addr = BASE + 32'(MEMSZ) - 32'($urandom_range(0, 8));
        default: addr = BASE + 32'($urandom_range(0, 63));
      endcase
      applyStimulus(op, addr, $urandom, $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", 32'(sbQ.size()), 32'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
